membank_burst: RTL
==================

MEMBANK_BURST -- requirements
Module: membank_burst

Interface
REQ-001 Parameter DATA_W, default 32, word width in bits.
REQ-002 Parameter ADDR_W, default 28, word address width.
REQ-003 Parameter DEPTH, default 256, words stored; power of two.
REQ-004 Parameter BURST_LEN, default 4, beats per burst; power of two, ≤ DEPTH.
REQ-005 Parameter RD_LAT, default 2, cycles from request accept to first read beat; range 1..7.
REQ-006 clk  in  1  single clock, all state on rising edge.
REQ-007 rst  in  1  reset, asynchronous and active-high.
REQ-008 req_valid  in  1  request present.
REQ-009 req_ready  out  1  block can accept a request.
REQ-010 req_we  in  1  1 = write burst, 0 = read burst.
REQ-011 req_addr  in  ADDR_W  word address of critical (first) beat.
REQ-012 wdata_valid / wdata  in  1 / DATA_W  write beat present / payload.
REQ-013 wdata_ready  out  1  write beat accepted when high with wdata_valid.
REQ-014 rdata_valid / rdata / rdata_last  out  1 / DATA_W / 1  read beat, payload, final beat flag.
REQ-015 rdata_ready  in  1  consumer accepts read beat.

Function
REQ-016 Index = req_addr[log2(DEPTH)-1:0]; upper address bits ignored.
REQ-017 Burst is wrapping: beat k targets {index high bits, (index low log2(BURST_LEN) bits + k) mod BURST_LEN}; never crosses a BURST_LEN-aligned line.
REQ-018 FSM states: IDLE, RD_WAIT, RD_BURST, WR_BURST.
REQ-019 IDLE: req_ready=1; req_valid&req_ready captures addr/we; we=1 -> WR_BURST, we=0 -> RD_WAIT.
REQ-020 RD_WAIT: latency counter counts RD_LAT-1 cycles after accept, then -> RD_BURST so first rdata_valid rises exactly RD_LAT cycles after accept edge.
REQ-021 RD_BURST: rdata_valid=1; rdata, rdata_last stable while rdata_ready=0; beat advances only on rdata_valid&rdata_ready.
REQ-022 rdata_last=1 on beat BURST_LEN-1 only; its handshake -> IDLE.
REQ-023 WR_BURST: wdata_ready=1; each wdata_valid&wdata_ready writes wdata to current beat address on that edge; beat BURST_LEN-1 handshake -> IDLE.
REQ-024 req_ready=0 in all states except IDLE; no request queuing; back-to-back bursts have ≥1 IDLE cycle.
REQ-025 wdata_ready=0 outside WR_BURST; rdata_valid=0 outside RD_BURST; stray wdata_valid ignored.
REQ-026 Read data reflects array contents at time of beat, including writes from an immediately preceding burst.
REQ-027 Beat counter width log2(BURST_LEN); wraps modulo BURST_LEN; BURST_LEN=1 gives single-beat transfers with rdata_last=1.
REQ-028 Array initial contents (simulation): all zero except word 0..3 = 0x50, 0x60, 0x70, 0x80.

Reset
REQ-029 rst=1 forces immediately: state IDLE, beat and latency counters 0, req_ready=1 after release, wdata_ready=0, rdata_valid=0, rdata_last=0, rdata=0.
REQ-030 Reset mid-burst aborts the burst; beats already written stay written; no further writes occur.
REQ-031 Reset does not clear array contents.

Structure
REQ-032 Package membank_pkg holds FSM state enum and default parameter constants.
REQ-033 Sub-module membank_array: DEPTH x DATA_W storage, one synchronous write port, one read port; no reset on storage.
REQ-034 Controller FSM, counters and handshake logic live in membank_burst.

Verification
REQ-035 Post-reset read addr=0, RD_LAT=2, rdata_ready=1 -> rdata_valid rises 2 cycles after accept; beats 0x50,0x60,0x70,0x80; rdata_last on 4th.
REQ-036 Wrap read addr=2 -> beats 0x70,0x80,0x50,0x60; rdata_last on 0x60.
REQ-037 Write burst addr=0x45, data 0xA1..0xA4 with one wdata_valid gap -> words 0x45,0x46,0x47,0x44 = 0xA1,0xA2,0xA3,0xA4; following read addr=0x44 returns 0xA4,0xA1,0xA2,0xA3.
REQ-038 Read with rdata_ready toggled 1,0,0,1 each cycle -> no beat lost or duplicated; rdata held stable while stalled.
REQ-039 rst pulsed after 2nd write beat -> outputs at reset values same cycle; only first 2 beats updated; next request accepted.
REQ-040 req_valid held high continuously -> req_ready low during bursts; exactly one accept per burst plus IDLE gap.

Source files
------------

// File: rtl/membank_pkg.sv
// Shared definitions for the wrapping-burst memory bank: controller states,
// default parameter values and the power-on contents of the first words.
package membank_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    RD_BURST = 2'd2,
    WR_BURST = 2'd3
  } state_e;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_ADDR_W    = 28;
  localparam int DEF_DEPTH     = 256;
  localparam int DEF_BURST_LEN = 4;
  localparam int DEF_RD_LAT    = 2;

  localparam logic [7:0] INIT_W0 = 8'h50;
  localparam logic [7:0] INIT_W1 = 8'h60;
  localparam logic [7:0] INIT_W2 = 8'h70;
  localparam logic [7:0] INIT_W3 = 8'h80;

endpackage

// File: rtl/membank_array.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port.
// Storage has no reset; words 0..3 power up preloaded, the rest zero.
module membank_array
  import membank_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH] = '{
    0: DATA_W'(INIT_W0),
    1: DATA_W'(INIT_W1),
    2: DATA_W'(INIT_W2),
    3: DATA_W'(INIT_W3),
    default: '0
  };

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/membank_burst.sv
// Burst controller for a single-port memory bank: wrapping read/write bursts of
// BURST_LEN beats, fixed read latency, valid/ready handshakes on every channel.
module membank_burst
  import membank_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int RD_LAT    = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              wdata_valid,
  input  logic [DATA_W-1:0] wdata,
  output logic              wdata_ready,
  output logic              rdata_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_last,
  input  logic              rdata_ready
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [IDX_W-1:0]  LINE_MASK = IDX_W'(BURST_LEN - 1);
  localparam logic [BEAT_W-1:0] BEAT_MASK = BEAT_W'(BURST_LEN - 1);
  localparam logic [2:0]        LAT_LAST  = 3'(RD_LAT - 1);

  state_e            state, state_nxt;
  logic [IDX_W-1:0]  idx_q;
  logic [BEAT_W-1:0] beat_cnt;
  logic [2:0]        lat_cnt;
  logic [IDX_W-1:0]  beat_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              last_beat, accept, rd_hs, wr_hs;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^req_addr[ADDR_W-1:IDX_W];

  assign accept    = req_valid && req_ready;
  assign rd_hs     = rdata_valid && rdata_ready;
  assign wr_hs     = wdata_valid && wdata_ready;
  assign last_beat = (beat_cnt == BEAT_MASK);

  // Wrapping beat address: line base stays fixed, offset rotates inside the line.
  assign beat_addr = (idx_q & ~LINE_MASK) | ((idx_q + IDX_W'(beat_cnt)) & LINE_MASK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      lat_cnt  <= '0;
    end else if (accept) begin
      beat_cnt <= '0;
      lat_cnt  <= '0;
    end else begin
      if (state == RD_WAIT) lat_cnt <= lat_cnt + 3'd1;
      if (rd_hs || wr_hs)   beat_cnt <= (beat_cnt + 1'b1) & BEAT_MASK;
    end
  end

  // Captured address is datapath state and is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (accept) idx_q <= req_addr[IDX_W-1:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (req_valid) state_nxt = req_we ? WR_BURST : RD_WAIT;
      RD_WAIT:  if (lat_cnt == LAT_LAST) state_nxt = RD_BURST;
      RD_BURST: if (rd_hs && last_beat) state_nxt = IDLE;
      WR_BURST: if (wr_hs && last_beat) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = 1'b0;
    wdata_ready = 1'b0;
    rdata_valid = 1'b0;
    rdata_last  = 1'b0;
    rdata       = '0;
    case (state)
      IDLE:     req_ready = 1'b1;
      RD_BURST: begin
        rdata_valid = 1'b1;
        rdata_last  = last_beat;
        rdata       = mem_rdata;
      end
      WR_BURST: wdata_ready = 1'b1;
      default:  ;
    endcase
  end

  membank_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (wr_hs),
    .waddr (beat_addr),
    .wdata (wdata),
    .raddr (beat_addr),
    .rdata (mem_rdata)
  );

endmodule
